mult8_nibble_seq: RTL and testbench



---
 rtl/mult8_nibble_seq.sv | 138 +++++++++++++
 tb/tb_mult8_nibble_seq.sv | 151 +++++++++++++++
 2 files changed

// File: rtl/mult8_nibble_seq.sv
// Unsigned 8x8->16 multiplier that reuses one 4x4 multiplier over up to four nibble-pair steps.
// Latency: popcount(step mask) cycles from the accept edge to out_valid; a zero mask reaches DONE on the accept edge.
// Backpressure: holds the result in DONE while out_ready=0; in_ready is high only in IDLE, so there is one bubble between results.

// 4x4 unsigned combinational multiplier: sum of four shifted partial-product rows
module mul4_array (
   input  logic [3:0] x,
   input  logic [3:0] y,
   output logic [7:0] p
);
   logic [7:0] row0, row1, row2, row3;

   // Build AND rows and add them; fits in 8 bits (max 15*15 = 225)
   always_comb begin
      row0 = {4'b0000, x & {4{y[0]}}};
      row1 = {3'b000,  x & {4{y[1]}}, 1'b0};
      row2 = {2'b00,   x & {4{y[2]}}, 2'b00};
      row3 = {1'b0,    x & {4{y[3]}}, 3'b000};
      p    = row0 + row1 + row2 + row3;
   end
endmodule

module mult8_nibble_seq #(
   parameter bit SKIP_ZERO = 1'b1
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [7:0]  a,
   input  logic [7:0]  b,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [15:0] prod,
   output logic        busy
);
   typedef enum logic [1:0] {IDLE, MUL, DONE} state_t;

   state_t      state_q, state_d;
   logic [7:0]  a_reg, b_reg;
   logic [15:0] acc;
   logic [3:0]  mask;

   logic [3:0]  mask_init;
   logic [3:0]  sel;
   logic [3:0]  nib_a, nib_b;
   logic [3:0]  shift;
   logic [7:0]  mul_out;
   logic [15:0] pp;
   logic        last_step;
   logic        accept;

   assign accept = (state_q == IDLE) && in_valid;

   // Step mask for a new request: k0=aL*bL, k1=aH*bL, k2=aL*bH, k3=aH*bH
   always_comb begin
      mask_init = 4'b1111;
      if (SKIP_ZERO) begin
         mask_init[0] = (|a[3:0]) && (|b[3:0]);
         mask_init[1] = (|a[7:4]) && (|b[3:0]);
         mask_init[2] = (|a[3:0]) && (|b[7:4]);
         mask_init[3] = (|a[7:4]) && (|b[7:4]);
      end
   end

   // Pick the lowest pending step and route its nibble pair and shift amount
   always_comb begin
      sel   = mask & 4'(~mask + 4'd1);
      nib_a = 4'h0;
      nib_b = 4'h0;
      shift = 4'd0;
      if (sel[0]) begin
         nib_a = a_reg[3:0];
         nib_b = b_reg[3:0];
         shift = 4'd0;
      end else if (sel[1]) begin
         nib_a = a_reg[7:4];
         nib_b = b_reg[3:0];
         shift = 4'd4;
      end else if (sel[2]) begin
         nib_a = a_reg[3:0];
         nib_b = b_reg[7:4];
         shift = 4'd4;
      end else if (sel[3]) begin
         nib_a = a_reg[7:4];
         nib_b = b_reg[7:4];
         shift = 4'd8;
      end
      pp        = {8'h00, mul_out} << shift;
      last_step = ((mask & ~sel) == 4'b0000);
   end

   mul4_array u_mul4 (
      .x (nib_a),
      .y (nib_b),
      .p (mul_out)
   );

   // State register
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) state_q <= IDLE;
      else          state_q <= state_d;
   end

   // Next-state logic: IDLE accepts, MUL runs pending steps, DONE waits for the consumer
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE: if (in_valid) state_d = (mask_init != 4'b0000) ? MUL : DONE;
         MUL:  if (last_step) state_d = DONE;
         DONE: if (out_ready) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Operand capture, step-mask retirement and shift/accumulate
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         a_reg <= 8'h00;
         b_reg <= 8'h00;
         acc   <= 16'h0000;
         mask  <= 4'b0000;
      end else if (accept) begin
         a_reg <= a;
         b_reg <= b;
         acc   <= 16'h0000;
         mask  <= mask_init;
      end else if (state_q == MUL) begin
         acc   <= acc + pp;
         mask  <= mask & ~sel;
      end
   end

   assign in_ready  = (state_q == IDLE);
   assign out_valid = (state_q == DONE);
   assign busy      = (state_q != IDLE);
   assign prod      = acc;
endmodule

// File: tb/tb_mult8_nibble_seq.sv
module tb_mult8_nibble_seq;
   logic        clk;
   logic [1:0]  reset_n;
   logic [1:0]  in_valid;
   logic [1:0]  in_ready;
   logic [7:0]  a [2];
   logic [7:0]  b [2];
   logic [1:0]  out_valid;
   logic [1:0]  out_ready;
   logic [15:0] prod [2];
   logic [1:0]  busy;

   int checks = 0;
   int errors = 0;

   // Instance 0 always runs 4 steps, instance 1 skips zero-nibble steps
   mult8_nibble_seq #(.SKIP_ZERO(1'b0)) dut0 (
      .clk(clk), .reset_n(reset_n[0]), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
      .a(a[0]), .b(b[0]), .out_valid(out_valid[0]), .out_ready(out_ready[0]),
      .prod(prod[0]), .busy(busy[0])
   );

   mult8_nibble_seq #(.SKIP_ZERO(1'b1)) dut1 (
      .clk(clk), .reset_n(reset_n[1]), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
      .a(a[1]), .b(b[1]), .out_valid(out_valid[1]), .out_ready(out_ready[1]),
      .prod(prod[1]), .busy(busy[1])
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Issue one request, count MUL cycles, check result, then drain with out_ready=1
   task automatic run_op(input int d, input logic [7:0] av, input logic [7:0] bv,
                         input int lat, input logic [15:0] exp, input string tag);
      chk({tag, "/in_ready_pre"}, {15'b0, in_ready[d]}, 16'd1);
      in_valid[d]  = 1'b1;
      a[d]         = av;
      b[d]         = bv;
      out_ready[d] = 1'b1;
      tick();
      in_valid[d] = 1'b0;
      a[d]        = 8'hA5;
      b[d]        = 8'h5A;
      for (int i = 0; i < lat; i++) begin
         chk($sformatf("%s/out_valid_early%0d", tag, i), {15'b0, out_valid[d]}, 16'd0);
         chk($sformatf("%s/busy%0d", tag, i), {15'b0, busy[d]}, 16'd1);
         tick();
      end
      chk({tag, "/out_valid"}, {15'b0, out_valid[d]}, 16'd1);
      chk({tag, "/prod"}, prod[d], exp);
      tick();
      chk({tag, "/out_valid_post"}, {15'b0, out_valid[d]}, 16'd0);
      chk({tag, "/in_ready_post"}, {15'b0, in_ready[d]}, 16'd1);
      chk({tag, "/busy_post"}, {15'b0, busy[d]}, 16'd0);
      out_ready[d] = 1'b0;
   endtask

   initial begin
      reset_n   = 2'b00;
      in_valid  = 2'b00;
      out_ready = 2'b00;
      a[0] = 8'h00; a[1] = 8'h00;
      b[0] = 8'h00; b[1] = 8'h00;
      tick();
      tick();
      reset_n = 2'b11;
      tick();

      // Reset state on both builds
      for (int d = 0; d < 2; d++) begin
         chk($sformatf("rst%0d/prod", d), prod[d], 16'h0000);
         chk($sformatf("rst%0d/out_valid", d), {15'b0, out_valid[d]}, 16'd0);
         chk($sformatf("rst%0d/busy", d), {15'b0, busy[d]}, 16'd0);
         chk($sformatf("rst%0d/in_ready", d), {15'b0, in_ready[d]}, 16'd1);
      end

      // Full four-step products
      run_op(1, 8'h12, 8'h34, 4, 16'h03A8, "s1_12x34");
      run_op(0, 8'hFF, 8'hFF, 4, 16'hFE01, "s0_FFxFF");
      run_op(1, 8'hFF, 8'hFF, 4, 16'hFE01, "s1_FFxFF");

      // Skipped steps: single-step and zero-mask cases
      run_op(1, 8'h0F, 8'h0F, 1, 16'h00E1, "s1_0Fx0F");
      run_op(1, 8'hF0, 8'h0F, 1, 16'h0E10, "s1_F0x0F");
      run_op(1, 8'h00, 8'h55, 0, 16'h0000, "s1_00x55");
      run_op(0, 8'h00, 8'h55, 4, 16'h0000, "s0_00x55");

      // Backpressure: result held, competing request ignored until IDLE
      in_valid[1] = 1'b1; a[1] = 8'h12; b[1] = 8'h34; out_ready[1] = 1'b0;
      tick();
      a[1] = 8'h99; b[1] = 8'h01;
      for (int i = 0; i < 4; i++) tick();
      for (int i = 0; i < 5; i++) begin
         chk($sformatf("bp/out_valid%0d", i), {15'b0, out_valid[1]}, 16'd1);
         chk($sformatf("bp/prod%0d", i), prod[1], 16'h03A8);
         chk($sformatf("bp/in_ready%0d", i), {15'b0, in_ready[1]}, 16'd0);
         tick();
      end
      out_ready[1] = 1'b1;
      tick();
      chk("bp/bubble_out_valid", {15'b0, out_valid[1]}, 16'd0);
      chk("bp/bubble_in_ready", {15'b0, in_ready[1]}, 16'd1);
      chk("bp/bubble_prod", prod[1], 16'h03A8);
      tick();
      in_valid[1] = 1'b0;
      chk("bp/new_accept_busy", {15'b0, busy[1]}, 16'd1);
      tick();
      chk("bp/new_mid_out_valid", {15'b0, out_valid[1]}, 16'd0);
      tick();
      chk("bp/new_out_valid", {15'b0, out_valid[1]}, 16'd1);
      chk("bp/new_prod", prod[1], 16'h0099);
      tick();
      chk("bp/new_drained", {15'b0, out_valid[1]}, 16'd0);
      out_ready[1] = 1'b0;

      // Reset in the middle of an operation
      in_valid[1] = 1'b1; a[1] = 8'h12; b[1] = 8'h34;
      tick();
      in_valid[1] = 1'b0;
      tick();
      tick();
      chk("mid/partial_acc", prod[1], 16'h0048);
      chk("mid/busy", {15'b0, busy[1]}, 16'd1);
      reset_n[1] = 1'b0;
      #1;
      chk("mid/rst_prod", prod[1], 16'h0000);
      chk("mid/rst_out_valid", {15'b0, out_valid[1]}, 16'd0);
      chk("mid/rst_busy", {15'b0, busy[1]}, 16'd0);
      tick();
      reset_n[1] = 1'b1;
      tick();
      chk("mid/idle_after_rst", {15'b0, out_valid[1]}, 16'd0);
      run_op(1, 8'h03, 8'h05, 1, 16'h000F, "s1_03x05");

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
